pixel_writer: RTL and testbench

- Downstream stage of the square animator/drawer: accepts its per-cycle plot stream (x, y, colour) and writes each pixel into the 160x120 3-bit frame-buffer write port.
- Contains a small plot FIFO to absorb frame-buffer back-pressure.
- Implements a full-screen clear sweep on request.
- Computes the linear address y*160 + x and drops off-screen coordinates.

---
 rtl/pixel_writer_pkg.sv | 24 ++
 rtl/pixel_writer_if.sv | 25 ++
 rtl/pixel_writer_plot_fifo.sv | 36 +++
 rtl/pixel_writer.sv | 78 +++++++
 tb/tb_pixel_writer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pixel_writer_pkg.sv
// pixel_writer_pkg: shared screen geometry, widths, FSM encoding and address helper.
package pixel_writer_pkg;
    localparam int XMAX = 160;
    localparam int YMAX = 120;
    localparam int FB_AW = 15;
    localparam int CW = 3;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int PW = XW + YW + CW;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_t;

    // y*160 + x without a multiplier
    function automatic logic [FB_AW-1:0] lin_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic [FB_AW-1:0] yy;
        yy = FB_AW'(y);
        return (yy << 7) + (yy << 5) + FB_AW'(x);
    endfunction
endpackage

// File: rtl/pixel_writer_if.sv
// pixel_writer_if: plot stream, clear control and frame-buffer write port of pixel_writer.
interface pixel_writer_if;
    import pixel_writer_pkg::*;
    logic plot;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;
    logic in_ready;
    logic clear_req;
    logic clear_done;
    logic [FB_AW-1:0] fb_addr;
    logic [CW-1:0] fb_data;
    logic fb_we;
    logic fb_ready;
    logic [7:0] dropped;

    modport master (
        output plot, x, y, colour, clear_req, fb_ready,
        input  in_ready, clear_done, fb_addr, fb_data, fb_we, dropped
    );
    modport slave (
        input  plot, x, y, colour, clear_req, fb_ready,
        output in_ready, clear_done, fb_addr, fb_data, fb_we, dropped
    );
endinterface

// File: rtl/pixel_writer_plot_fifo.sv
// plot_fifo: synchronous FIFO with pointer-plus-wrap-bit full/empty and show-ahead read.
module plot_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         r_set,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;

    assign empty = wp == rp;
    assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    assign dout = mem[rp[AW-1:0]];

    always_ff @(posedge clk or posedge r_set) begin
        if (r_set) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + (AW+1)'(1);
            if (pop && !empty) rp <= rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/pixel_writer.sv
// pixel_writer: queues plots, writes them to the 160x120 frame buffer and runs the clear sweep.
module pixel_writer #(
    parameter int DEPTH = 4,
    parameter int XMAX = pixel_writer_pkg::XMAX,
    parameter int YMAX = pixel_writer_pkg::YMAX,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input logic clk,
    input logic r_set,
    pixel_writer_if.slave bus
);
    import pixel_writer_pkg::*;

    localparam logic [FB_AW-1:0] LAST = FB_AW'(XMAX * YMAX - 1);

    state_t state;
    logic [FB_AW-1:0] cnt;
    logic [PW-1:0] fifo_dout;
    logic full, empty, accept, on_screen, push, pop, out_free;

    assign out_free = !bus.fb_we || bus.fb_ready;
    // clear_done term holds in_ready low for the pulse cycle so it rises just after it
    assign bus.in_ready = !r_set && state == RUN && !full && !bus.clear_done;
    assign accept = bus.plot && bus.in_ready;
    assign on_screen = 32'(bus.x) < XMAX && 32'(bus.y) < YMAX;
    assign push = accept && on_screen;
    assign pop = !empty && out_free && (state == RUN || state == FLUSH);

    plot_fifo #(.DEPTH(DEPTH), .W(PW)) u_fifo (
        .clk(clk),
        .r_set(r_set),
        .push(push),
        .pop(pop),
        .din({bus.x, bus.y, bus.colour}),
        .dout(fifo_dout),
        .full(full),
        .empty(empty)
    );

    always_ff @(posedge clk or posedge r_set) begin
        if (r_set) begin
            state <= RUN;
            cnt <= '0;
            bus.fb_we <= 1'b0;
            bus.fb_addr <= '0;
            bus.fb_data <= '0;
            bus.clear_done <= 1'b0;
            bus.dropped <= '0;
        end else begin
            bus.clear_done <= 1'b0;
            if (accept && !on_screen && bus.dropped != 8'hff) bus.dropped <= bus.dropped + 8'd1;
            if (bus.fb_we && bus.fb_ready) bus.fb_we <= 1'b0;
            if (pop) begin
                bus.fb_we <= 1'b1;
                bus.fb_addr <= lin_addr(fifo_dout[PW-1 -: XW], fifo_dout[CW +: YW]);
                bus.fb_data <= fifo_dout[CW-1:0];
            end
            case (state)
                RUN: if (bus.clear_req) state <= FLUSH;
                FLUSH: if (empty && out_free) begin
                    state <= CLEAR;
                    cnt <= '0;
                end
                CLEAR: if (out_free) begin
                    bus.fb_we <= 1'b1;
                    bus.fb_addr <= cnt;
                    bus.fb_data <= CLEAR_COLOUR;
                    cnt <= cnt + FB_AW'(1);
                    if (cnt == LAST) state <= DONE;
                end
                DONE: if (bus.fb_we && bus.fb_ready) begin
                    bus.clear_done <= 1'b1;
                    state <= RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer: directed vectors with hand-computed expectations for pixel_writer.
module tb_pixel_writer;
    logic clk = 1'b0;
    logic r_set = 1'b1;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int we_cnt = 0;
    logic [17:0] wlog [$];

    pixel_writer_if bus();

    pixel_writer dut (
        .clk(clk),
        .r_set(r_set),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // a write seen with fb_we & fb_ready at mid-cycle completes on the next rising edge
    always @(negedge clk) begin
        if (!r_set) begin
            if (bus.fb_we && bus.fb_ready) wlog.push_back({bus.fb_addr, bus.fb_data});
            if (bus.clear_done) done_cnt++;
            if (bus.fb_we) we_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
        int n = 0;
        bus.plot = 1'b1;
        bus.x = px;
        bus.y = py;
        bus.colour = pc;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("push_timeout", 0, 1);
        tick();
        bus.plot = 1'b0;
    endtask

    function automatic int pix_addr(input int i);
        return i * 160 + 10 + i;
    endfunction

    initial begin
        int base, n, ir, mm, d0, cnt;
        logic [17:0] e;
        bus.plot = 1'b0;
        bus.x = '0;
        bus.y = '0;
        bus.colour = '0;
        bus.clear_req = 1'b0;
        bus.fb_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_fb_we", 32'(bus.fb_we), 0);
        check("rst_fb_addr", 32'(bus.fb_addr), 0);
        check("rst_fb_data", 32'(bus.fb_data), 0);
        check("rst_clear_done", 32'(bus.clear_done), 0);
        check("rst_dropped", 32'(bus.dropped), 0);
        r_set = 1'b0;
        bus.fb_ready = 1'b1;
        tick();
        check("run_in_ready", 32'(bus.in_ready), 1);

        // single pixel latency and address
        base = wlog.size();
        push(8'd3, 7'd2, 3'd5);
        check("t1_we_not_yet", 32'(bus.fb_we), 0);
        tick();
        check("t1_we", 32'(bus.fb_we), 1);
        check("t1_addr", 32'(bus.fb_addr), 323);
        check("t1_data", 32'(bus.fb_data), 5);
        tick();
        check("t1_we_drop", 32'(bus.fb_we), 0);
        tick();
        check("t1_write_count", 32'(wlog.size() - base), 1);

        // back-pressure fills FIFO behind the output register
        base = wlog.size();
        bus.fb_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(8'(10 + i), 7'(i), 3'(i));
        check("t2_full_in_ready", 32'(bus.in_ready), 0);
        check("t2_held_we", 32'(bus.fb_we), 1);
        check("t2_held_addr", 32'(bus.fb_addr), 32'(pix_addr(1)));
        bus.plot = 1'b1;
        bus.x = 8'd16;
        bus.y = 7'd6;
        bus.colour = 3'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_wait_in_ready", 32'(bus.in_ready), 0);
            check("t2_stable_addr", 32'(bus.fb_addr), 32'(pix_addr(1)));
        end
        bus.fb_ready = 1'b1;
        push(8'd16, 7'd6, 3'd6);
        for (int i = 0; i < 10; i++) tick();
        check("t2_write_count", 32'(wlog.size() - base), 6);
        for (int i = 1; i <= 6 && base + i - 1 < wlog.size(); i++) begin
            e = wlog[base + i - 1];
            check("t2_order_addr", 32'(e[17:3]), 32'(pix_addr(i)));
            check("t2_order_data", 32'(e[2:0]), 32'(i));
        end

        // off-screen drops and the bottom-right corner
        base = wlog.size();
        push(8'd160, 7'd0, 3'd1);
        push(8'd0, 7'd120, 3'd2);
        push(8'd159, 7'd119, 3'd7);
        for (int i = 0; i < 5; i++) tick();
        check("t3_dropped", 32'(bus.dropped), 2);
        check("t3_write_count", 32'(wlog.size() - base), 1);
        if (wlog.size() > base) begin
            e = wlog[base];
            check("t3_corner_addr", 32'(e[17:3]), 19199);
            check("t3_corner_data", 32'(e[2:0]), 7);
        end

        // pending pixels drain before a full clear sweep
        base = wlog.size();
        d0 = done_cnt;
        push(8'd20, 7'd1, 3'd3);
        push(8'd21, 7'd2, 3'd4);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        n = 0;
        ir = 0;
        while (!bus.clear_done && n < 25000) begin
            if (bus.in_ready) ir++;
            tick();
            n++;
        end
        check("t4_clear_done_seen", 32'(bus.clear_done), 1);
        check("t4_in_ready_low", 32'(ir), 0);
        check("t4_in_ready_at_done", 32'(bus.in_ready), 0);
        tick();
        check("t4_in_ready_after", 32'(bus.in_ready), 1);
        tick();
        tick();
        check("t4_done_pulses", 32'(done_cnt - d0), 1);
        check("t4_write_count", 32'(wlog.size() - base), 19202);
        if (wlog.size() >= base + 19202) begin
            check("t4_pix0", 32'(wlog[base]), 32'({15'd180, 3'd3}));
            check("t4_pix1", 32'(wlog[base + 1]), 32'({15'd341, 3'd4}));
            mm = 0;
            for (int k = 0; k < 19200; k++) begin
                e = wlog[base + 2 + k];
                if (e[17:3] != 15'(k) || e[2:0] != 3'd0) mm++;
            end
            check("t4_sweep_mismatches", 32'(mm), 0);
        end

        // reset in the middle of a clear sweep
        d0 = done_cnt;
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        n = 0;
        while (!(bus.fb_we && bus.fb_addr == 15'd500) && n < 2000) begin
            tick();
            n++;
        end
        check("t5_reached_500", 32'(bus.fb_addr), 500);
        r_set = 1'b1;
        #1;
        check("t5_we_async", 32'(bus.fb_we), 0);
        check("t5_in_ready_rst", 32'(bus.in_ready), 0);
        cnt = wlog.size();
        if (cnt > 0) begin
            e = wlog[cnt - 1];
            check("t5_last_addr", 32'(e[17:3]), 499);
        end
        tick();
        tick();
        r_set = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t5_in_ready", 32'(bus.in_ready), 1);
        check("t5_dropped", 32'(bus.dropped), 0);
        check("t5_fb_we", 32'(bus.fb_we), 0);
        check("t5_no_writes", 32'(wlog.size() - cnt), 0);
        check("t5_no_done", 32'(done_cnt - d0), 0);

        // drop counter saturation
        base = wlog.size();
        d0 = we_cnt;
        for (int i = 0; i < 300; i++) begin
            push(8'd200, 7'(i % 128), 3'd1);
            if (i == 253) check("t6_dropped_254", 32'(bus.dropped), 254);
        end
        check("t6_dropped_sat", 32'(bus.dropped), 255);
        tick();
        tick();
        check("t6_no_we", 32'(we_cnt - d0), 0);
        check("t6_no_writes", 32'(wlog.size() - base), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
